// File: rtl/seg_led_decoder_if.sv
// -----------------------------------------------------------------------------
// seg_led_decoder_if
//   Bundles the multiplexed 7-segment display lines sniffed by the decoder and
//   the decoded frame it reports back.
//
//   seg_sel    [5:0]  digit select, active low, bit0 = least significant digit
//   seg_led    [7:0]  segment lines, active low, bit7 = dp, bits6:0 = g..a
//   data       [19:0] binary magnitude of the last valid frame
//   point      [5:0]  decimal-point mask of the last valid frame, active high
//   sign              minus sign present in the last valid frame
//   data_valid        one-cycle pulse when data/point/sign update
//   frame_err         one-cycle pulse when a frame is rejected
//
//   master : the display-driver side (drives seg_sel/seg_led)
//   slave  : the decoder side
// -----------------------------------------------------------------------------
interface seg_led_decoder_if;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        data_valid;
  logic        frame_err;

  modport master (
    output seg_sel, seg_led,
    input  data, point, sign, data_valid, frame_err
  );

  modport slave (
    input  seg_sel, seg_led,
    output data, point, sign, data_valid, frame_err
  );
endinterface

// File: rtl/seg_led_decoder.sv
// -----------------------------------------------------------------------------
// seg_led_decoder
//   Watches a multiplexed 6-digit 7-segment display bus, waits for each digit
//   to settle, captures it, and once all six digits are present validates the
//   frame (leading blanks, optional minus, numerals) and converts it to binary.
//
//   Parameters
//     SETTLE_CYC : cycles the synchronised select/segments must hold unchanged
//                  before a digit is captured
//   Ports
//     clk        : system clock
//     rst_n      : asynchronous active-low reset
//     bus        : seg_led_decoder_if.slave (see interface for signal list)
// -----------------------------------------------------------------------------
module seg_led_decoder #(
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_led_decoder_if.slave bus
);

  typedef enum logic [1:0] {COLLECT, CHECK, CONV, DONE} state_t;

  localparam int unsigned CNT_W      = $clog2(SETTLE_CYC + 1);
  localparam logic [3:0]  CODE_BLANK = 4'd10;
  localparam logic [3:0]  CODE_MINUS = 4'd11;

  // ---------------------------------------------------------------------------
  // Input synchronisers. Idle display lines are all-ones, so that is the
  // reset value; the third stage only exists for change detection.
  // ---------------------------------------------------------------------------
  logic [5:0] sel_meta, sel_s, sel_prev;
  logic [7:0] led_meta, led_s, led_prev;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_meta <= '1;
      sel_s    <= '1;
      sel_prev <= '1;
      led_meta <= '1;
      led_s    <= '1;
      led_prev <= '1;
    end else begin
      sel_meta <= bus.seg_sel;
      sel_s    <= sel_meta;
      sel_prev <= sel_s;
      led_meta <= bus.seg_led;
      led_s    <= led_meta;
      led_prev <= led_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Select decode: count active (zero) bits and locate the selected digit.
  // ---------------------------------------------------------------------------
  logic [2:0] zero_cnt;
  logic [2:0] sel_idx;
  logic       sel_idle;
  logic       sel_legal;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    zero_cnt = '0;
    sel_idx  = '0;
    for (int i = 0; i < 6; i++) begin
      if (!sel_s[i]) begin
        zero_cnt = zero_cnt + 3'd1;
        sel_idx  = 3'(i);
      end
    end
  end

  assign sel_idle  = (zero_cnt == 3'd0);
  assign sel_legal = (zero_cnt == 3'd1);

  // ---------------------------------------------------------------------------
  // Settle counter. Any change restarts it; it saturates at SETTLE_CYC so it
  // reaches the capture point only once per stable window. 'armed' makes sure
  // a digit is taken only once per select, even if its segments later change.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] settle_cnt;
  logic             armed;
  logic             changed;
  logic             sel_changed;
  logic             fire;

  assign sel_changed = (sel_s != sel_prev);
  assign changed     = sel_changed || (led_s != led_prev);
  assign fire        = armed && !changed && !sel_idle &&
                       (settle_cnt == CNT_W'(SETTLE_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      if (changed || sel_idle) begin
        settle_cnt <= '0;
      end else if (settle_cnt != CNT_W'(SETTLE_CYC)) begin
        settle_cnt <= settle_cnt + CNT_W'(1);
      end

      if (sel_changed) begin
        armed <= 1'b1;
      end else if (fire) begin
        armed <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Segment decode: {legal, code}, code 0..9 numerals, 10 blank, 11 minus.
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    case (pat)
      7'h40:   return {1'b1, 4'd0};
      7'h79:   return {1'b1, 4'd1};
      7'h24:   return {1'b1, 4'd2};
      7'h30:   return {1'b1, 4'd3};
      7'h19:   return {1'b1, 4'd4};
      7'h12:   return {1'b1, 4'd5};
      7'h02:   return {1'b1, 4'd6};
      7'h78:   return {1'b1, 4'd7};
      7'h00:   return {1'b1, 4'd8};
      7'h10:   return {1'b1, 4'd9};
      7'h7F:   return {1'b1, CODE_BLANK};
      7'h3F:   return {1'b1, CODE_MINUS};
      default: return {1'b0, 4'd0};
    endcase
  endfunction

  // Frame grammar scanned from digit 5 down: blanks*, minus?, numeral+.
  function automatic logic frame_good(input logic [5:0][3:0] c);
    logic [1:0] phase;  // 0: leading blanks, 1: after minus, 2: in numerals
    logic       ok;
    phase = 2'd0;
    ok    = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      if (c[i] == CODE_BLANK) begin
        if (phase != 2'd0) ok = 1'b0;
      end else if (c[i] == CODE_MINUS) begin
        if (phase != 2'd0) ok = 1'b0;
        else               phase = 2'd1;
      end else begin
        phase = 2'd2;
      end
    end
    return ok && (phase == 2'd2);
  endfunction

  function automatic logic has_minus(input logic [5:0][3:0] c);
    logic m;
    m = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (c[i] == CODE_MINUS) m = 1'b1;
    end
    return m;
  endfunction

  logic [4:0] seg_dec;
  logic       pat_legal;
  logic [3:0] pat_code;

  assign seg_dec   = decode_seg(led_s[6:0]);
  assign pat_legal = seg_dec[4];
  assign pat_code  = seg_dec[3:0];

  // ---------------------------------------------------------------------------
  // Digit store. Its contents are only meaningful under the capture mask.
  // ---------------------------------------------------------------------------
  logic [5:0][3:0] codes;
  logic [5:0]      dp_bits;
  logic            store_en;

  // NOTE: the digit store has no reset; the mask (which is reset) decides when
  // its contents are valid, and every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (store_en) begin
      codes[sel_idx]   <= pat_code;
      dp_bits[sel_idx] <= ~led_s[7];
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM and conversion datapath.
  // ---------------------------------------------------------------------------
  state_t      state, state_next;
  logic [5:0]  mask, mask_next;
  logic        err_next, valid_next;
  logic [19:0] acc, acc_next;
  logic [2:0]  conv_idx;
  logic        minus_seen;
  logic [3:0]  cur_code;
  logic [3:0]  cur_val;

  logic [19:0] data_q;
  logic [5:0]  point_q;
  logic        sign_q;
  logic        data_valid_q;
  logic        frame_err_q;

  // Blank and minus contribute 0 to the magnitude.
  assign cur_code = codes[conv_idx];
  assign cur_val  = (cur_code < 4'd10) ? cur_code : 4'd0;
  assign acc_next = acc * 20'd10 + {16'd0, cur_val};

  always_comb begin
    state_next = state;
    mask_next  = mask;
    store_en   = 1'b0;
    err_next   = 1'b0;
    valid_next = 1'b0;
    unique case (state)
      COLLECT: begin
        if (fire) begin
          if (sel_legal && pat_legal) begin
            store_en  = 1'b1;
            mask_next = mask | (6'b000001 << sel_idx);
            if (mask_next == 6'b111111) state_next = CHECK;
          end else begin
            err_next  = 1'b1;
            mask_next = '0;
          end
        end
      end
      CHECK: begin
        if (frame_good(codes)) begin
          state_next = CONV;
        end else begin
          err_next   = 1'b1;
          mask_next  = '0;
          state_next = COLLECT;
        end
      end
      CONV: begin
        // The final step loads the outputs so data_valid lands in DONE.
        if (conv_idx == 3'd0) begin
          valid_next = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        mask_next  = '0;
        state_next = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= COLLECT;
      mask         <= '0;
      frame_err_q  <= 1'b0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      point_q      <= '0;
      sign_q       <= 1'b0;
      acc          <= '0;
      conv_idx     <= '0;
      minus_seen   <= 1'b0;
    end else begin
      state        <= state_next;
      mask         <= mask_next;
      frame_err_q  <= err_next;
      data_valid_q <= valid_next;
      case (state)
        CHECK: begin
          acc        <= '0;
          conv_idx   <= 3'd5;
          minus_seen <= has_minus(codes);
        end
        CONV: begin
          acc      <= acc_next;
          conv_idx <= conv_idx - 3'd1;
          if (valid_next) begin
            data_q  <= acc_next;
            point_q <= dp_bits;
            sign_q  <= minus_seen;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data       = data_q;
  assign bus.point      = point_q;
  assign bus.sign       = sign_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;

endmodule
